imem_fetch_arbiter: RTL
=======================

Name: imem_fetch_arbiter

Overview:
- Shares the single synchronous instruction memory among the cores of the 8-core matrix-multiply processor.
- Round-robin arbitration grants one fetch per cycle and drives the memory's read/address inputs.
- Returns each instruction word to the requesting core one cycle later.
- Decodes the END instruction to track per-core halt status and whole-program completion.

Parameters:
- NUM_CORES, 8, number of requesting cores (2..16).
- ADDR_W, 16, instruction address width.
- DATA_W, 16, instruction word width: operand in [15:8], opcode in [7:0].

Ports:
- clk  input  1  clock.
- rst  input  1  reset, asynchronous, active-high.
- core_req  input  NUM_CORES  per-core fetch request; held until matching core_rvalid.
- core_addr  input  NUM_CORES*ADDR_W  per-core fetch address; core i uses slice [i*ADDR_W +: ADDR_W].
- core_rvalid  output  NUM_CORES  one-hot: fetch data valid for core i this cycle.
- core_rdata  output  DATA_W  instruction word, broadcast; qualified by core_rvalid.
- core_halted  output  NUM_CORES  core has fetched END.
- all_done  output  1  all cores halted.
- clear_halt  input  1  synchronous clear of all halt flags.
- fetch_count  output  32  total completed fetches, wraps.
- mem_read  output  1  memory read enable.
- mem_address  output  ADDR_W  memory address.
- mem_data_out  input  DATA_W  memory read data; valid the cycle after mem_read is sampled.

Behaviour:
- Reset values: rr_ptr=0, inflight_valid=0, inflight_id=0, core_halted=0, all_done=0, fetch_count=0. Consequently core_rvalid=0 during reset. Any read in flight when reset asserts is discarded and never returned.
- Eligibility: eligible[i] = core_req[i] & ~core_halted[i] & ~(inflight_valid & inflight_id==i).
- Arbitration (combinational each cycle): pick the first eligible core scanning rr_ptr, rr_ptr+1, ... modulo NUM_CORES.
- Outputs during a grant: mem_read=1 and mem_address=core_addr[grant_id] (combinational).
- Outputs with no eligible core: mem_read=0, mem_address=0.
- On the clock edge after a grant:
  - inflight_valid <= 1 and inflight_id <= grant_id.
  - rr_ptr <= (grant_id+1) mod NUM_CORES.
  - With no grant: inflight_valid <= 0 and rr_ptr holds.
- Return: core_rvalid = inflight_valid ? onehot(inflight_id) : 0; core_rdata = mem_data_out.
- Latency: request granted in cycle k → core_rvalid in cycle k+1.
- Throughput: one fetch per cycle across cores. A single core gets at most one fetch every 2 cycles, because the in-flight mask blocks a duplicate grant of the same, still-asserted request.
- Core obligation: when it sees core_rvalid, it either drops core_req or presents the next address in the following cycle.
- END detect: when core_rvalid[i] and core_rdata=={8'd0,OP_END}, set core_halted[i] at the next edge. Requests from halted cores are ignored.
- clear_halt:
  - Clears all halt flags at the next edge.
  - If END is detected in the same cycle, clear_halt wins.
  - Does not affect inflight state or rr_ptr.
- all_done is registered: all_done <= &core_halted_next.
- fetch_count increments by 1 in every cycle where core_rvalid is nonzero. It wraps from 0xFFFFFFFF to 0.
- core_addr changing while its core is not granted has no effect. Addresses are not range-checked; the memory's index truncation applies.

Decomposition:
- Package imem_arb_pkg holds:
  - OP_END=8'd30, OP_CLAC=8'd4, OP_JPNZ=8'd16.
  - ADDR_W, DATA_W defaults.
  - A function for the onehot of a core id.
- Sub-module rr_priority_picker (NUM_CORES): inputs eligible vector and rr_ptr; outputs grant_valid and grant_id. Purely combinational with a rotate-and-priority-encode structure; instantiated once.

Test Plan:
- Single request: core 0 req addr 0x0000, memory word 0x0004 → mem_read=1, mem_address=0 in cycle k; core_rvalid=0x01 with core_rdata=0x0004 in k+1; fetch_count=1.
- Contention: cores 0, 3 and 7 request continuously with distinct addresses from rr_ptr=0 → grants 0,3,7,0,3,7 on consecutive cycles with no idle cycle; each core_rvalid appears exactly one cycle after its grant.
- Same-core back-to-back: only core 2 holds req → mem_read pattern 1,0,1,0; no duplicate core_rvalid for a single address.
- END handling: core 5 fetches addr 86 returning 0x001E → core_halted[5]=1 next edge. A further core 5 req yields no grant. clear_halt in the same cycle as the END return → core_halted[5] stays 0.
- Completion: all 8 cores fetch 0x001E → all_done=1 one cycle after the last halt set. Pulsing clear_halt → core_halted=0 and all_done=0 the next cycle.
- Reset mid-fetch: assert rst in the cycle after a grant → core_rvalid stays 0, fetch_count=0, rr_ptr=0. After release, the first grant goes to the lowest-index requester.

Source files
------------

// File: rtl/imem_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : imem_arb_pkg
//  Description : Shared opcodes, width defaults and a core-id one-hot helper
//                for the instruction-memory fetch arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
package imem_arb_pkg;

  // Opcodes living in the low byte of an instruction word
  localparam logic [7:0] OP_END  = 8'd30;
  localparam logic [7:0] OP_CLAC = 8'd4;
  localparam logic [7:0] OP_JPNZ = 8'd16;

  // Default instruction address and word widths
  localparam int DEF_ADDR_W = 16;
  localparam int DEF_DATA_W = 16;

  // Largest supported core count and the id width that covers it
  localparam int MAX_CORES = 16;
  localparam int CORE_ID_W = 4;

  // One-hot vector with only bit `id` set
  function automatic logic [MAX_CORES-1:0] core_onehot(input logic [CORE_ID_W-1:0] id);
    logic [MAX_CORES-1:0] v;
    v     = '0;
    v[id] = 1'b1;
    return v;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rr_priority_picker.sv
`default_nettype none
// ============================================================================
//  Module      : rr_priority_picker
//  Description : Combinational round-robin picker. Rotates the eligible
//                vector so the search starts at i_rr_ptr, priority-encodes
//                the lowest set bit, then rotates the result back.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_priority_picker #(
  parameter int NUM_CORES = 8,
  parameter int ID_W      = $clog2(NUM_CORES)
) (
  input  logic [NUM_CORES-1:0] i_eligible,
  input  logic [ID_W-1:0]      i_rr_ptr,
  output logic                 o_grant_valid,
  output logic [ID_W-1:0]      o_grant_id
);

  localparam logic [ID_W:0] C_NUM = (ID_W+1)'(NUM_CORES);

  logic [2*NUM_CORES-1:0] w_doubled;
  logic [NUM_CORES-1:0]   w_rotated;
  logic [ID_W-1:0]        w_offset;
  logic                   w_found;
  logic [ID_W:0]          w_sum;

  // Doubling the vector turns the rotate into a plain right shift
  assign w_doubled = {i_eligible, i_eligible};
  assign w_rotated = NUM_CORES'(w_doubled >> i_rr_ptr);

  // Lowest set bit of the rotated vector is the distance from the pointer
  always_comb begin
    w_found  = 1'b0;
    w_offset = '0;
    for (int i = NUM_CORES - 1; i >= 0; i--) begin
      if (w_rotated[i]) begin
        w_found  = 1'b1;
        w_offset = ID_W'(i);
      end
    end
  end

  // Undo the rotation modulo NUM_CORES
  assign w_sum         = {1'b0, i_rr_ptr} + {1'b0, w_offset};
  assign o_grant_id    = (w_sum >= C_NUM) ? ID_W'(w_sum - C_NUM) : ID_W'(w_sum);
  assign o_grant_valid = w_found;

endmodule
`default_nettype wire

// File: rtl/imem_fetch_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : imem_fetch_arbiter
//  Description : Round-robin sharing of one synchronous instruction memory
//                among NUM_CORES cores. One fetch is granted per cycle; data
//                returns to the requester one cycle later. END fetches set a
//                per-core halt flag; all_done reports that every core halted.
//  Revision    : 1.0 - initial release
// ============================================================================
module imem_fetch_arbiter
  import imem_arb_pkg::*;
#(
  parameter int NUM_CORES = 8,
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int DATA_W    = DEF_DATA_W
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_CORES-1:0]        core_req,
  input  logic [NUM_CORES*ADDR_W-1:0] core_addr,
  output logic [NUM_CORES-1:0]        core_rvalid,
  output logic [DATA_W-1:0]           core_rdata,
  output logic [NUM_CORES-1:0]        core_halted,
  output logic                        all_done,
  input  logic                        clear_halt,
  output logic [31:0]                 fetch_count,
  output logic                        mem_read,
  output logic [ADDR_W-1:0]           mem_address,
  input  logic [DATA_W-1:0]           mem_data_out
);

  localparam int ID_W = $clog2(NUM_CORES);

  logic [ID_W-1:0]      r_rr_ptr;
  logic                 r_inflight_valid;
  logic [ID_W-1:0]      r_inflight_id;
  logic [NUM_CORES-1:0] r_core_halted;
  logic                 r_all_done;
  logic [31:0]          r_fetch_count;

  logic [NUM_CORES-1:0] w_inflight_mask;
  logic [NUM_CORES-1:0] w_eligible;
  logic                 w_grant_valid;
  logic [ID_W-1:0]      w_grant_id;
  logic [ADDR_W-1:0]    w_addr [NUM_CORES];
  logic [NUM_CORES-1:0] w_end_hit;
  logic [NUM_CORES-1:0] w_halted_next;

  // Split the flat address bus into one entry per core
  for (genvar gi = 0; gi < NUM_CORES; gi++) begin : g_addr_unpack
    assign w_addr[gi] = core_addr[gi*ADDR_W +: ADDR_W];
  end

  // The core whose word is in flight must not be granted again until it returns
  assign w_inflight_mask = r_inflight_valid ? NUM_CORES'(core_onehot(CORE_ID_W'(r_inflight_id))) : '0;
  assign w_eligible      = core_req & ~r_core_halted & ~w_inflight_mask;

  rr_priority_picker #(
    .NUM_CORES (NUM_CORES),
    .ID_W      (ID_W)
  ) u_picker (
    .i_eligible    (w_eligible),
    .i_rr_ptr      (r_rr_ptr),
    .o_grant_valid (w_grant_valid),
    .o_grant_id    (w_grant_id)
  );

  assign mem_read    = w_grant_valid;
  assign mem_address = w_grant_valid ? w_addr[w_grant_id] : '0;

  // Returned word is broadcast; the in-flight one-hot tells who owns it
  assign core_rvalid = w_inflight_mask;
  assign core_rdata  = mem_data_out;

  assign w_end_hit     = (mem_data_out == DATA_W'(OP_END)) ? core_rvalid : '0;
  assign w_halted_next = clear_halt ? '0 : (r_core_halted | w_end_hit);

  // Track the outstanding read and advance the round-robin pointer past each winner
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rr_ptr         <= '0;
      r_inflight_valid <= 1'b0;
      r_inflight_id    <= '0;
    end else begin
      r_inflight_valid <= w_grant_valid;
      if (w_grant_valid) begin
        r_inflight_id <= w_grant_id;
        r_rr_ptr      <= (w_grant_id == ID_W'(NUM_CORES - 1)) ? '0 : w_grant_id + 1'b1;
      end
    end
  end

  // Halt flags and the registered all-cores-halted indication
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_core_halted <= '0;
      r_all_done    <= 1'b0;
    end else begin
      r_core_halted <= w_halted_next;
      r_all_done    <= &w_halted_next;
    end
  end

  // Count every cycle in which a word is handed back to a core
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fetch_count <= '0;
    end else if (|core_rvalid) begin
      r_fetch_count <= r_fetch_count + 32'd1;
    end
  end

  assign core_halted = r_core_halted;
  assign all_done    = r_all_done;
  assign fetch_count = r_fetch_count;

endmodule
`default_nettype wire
